// File: rtl/rvcore_axi_pkg.sv
// Shared AXI4-Lite types and arbitration constants for the rvcore interconnect.
package rvcore_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Index width that stays at least 1 bit so a single-master build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way grant: round-robin from ptr (mode=0) or lowest-index-wins (mode=1).
module rr_arbiter
    import rvcore_axi_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;
    int   start;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        start = mode ? 0 : int'(ptr);
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (start + i) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// N-to-1 AXI4-Lite read arbiter, one transaction in flight, registered request address.
//   state | meaning
//   IDLE  | grant an upstream request and capture its address/prot/index
//   ADDR  | present captured address downstream until m_arready
//   DATA  | route the read beat to the granted master until it accepts
module axi_lite_read_arbiter
    import rvcore_axi_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ARB_MODE    = 0
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [NUM_MASTERS-1:0]                s_arvalid,
    output logic [NUM_MASTERS-1:0]                s_arready,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_MASTERS-1:0][2:0]           s_arprot,
    output logic [NUM_MASTERS-1:0]                s_rvalid,
    input  logic [NUM_MASTERS-1:0]                s_rready,
    output logic [DATA_WIDTH-1:0]                 s_rdata,
    output logic [1:0]                            s_rresp,
    output logic                                  m_arvalid,
    input  logic                                  m_arready,
    output logic [ADDR_WIDTH-1:0]                 m_araddr,
    output logic [2:0]                            m_arprot,
    input  logic                                  m_rvalid,
    output logic                                  m_rready,
    input  logic [DATA_WIDTH-1:0]                 m_rdata,
    input  logic [1:0]                            m_rresp
);

    localparam int IW = idx_width(NUM_MASTERS);

    arb_state_t             state_q, state_d;
    logic [IW-1:0]          ptr_q, g_q, gnt_idx, ptr_next;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [2:0]             prot_q;
    logic                   r_done;

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .req   (s_arvalid),
        .ptr   (ptr_q),
        .mode  (ARB_MODE == ARB_FIXED),
        .grant (gnt_oh),
        .idx   (gnt_idx)
    );

    assign r_done    = (state_q == DATA) && m_rvalid && s_rready[g_q];
    assign ptr_next  = (g_q == IW'(NUM_MASTERS - 1)) ? '0 : g_q + 1'b1;
    assign m_araddr  = addr_q;
    assign m_arprot  = prot_q;
    assign m_arvalid = (state_q == ADDR);

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            prot_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |s_arvalid) begin
                g_q    <= gnt_idx;
                addr_q <= s_araddr[gnt_idx];
                prot_q <= s_arprot[gnt_idx];
            end
            if (r_done) begin
                ptr_q <= ptr_next;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        case (state_q)
            IDLE: begin
                // Gated by reset so nothing is accepted while the FSM is held.
                if (areset) begin
                    s_arready = gnt_oh;
                end
                if (|s_arvalid) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                s_rvalid[g_q] = m_rvalid;
                m_rready      = s_rready[g_q];
                s_rdata       = m_rdata;
                s_rresp       = m_rresp;
                if (r_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Scoreboard bench for axi_lite_read_arbiter: 2-master RR, 2-master fixed, 4-master RR.
module tb_axi_lite_read_arbiter;
    import rvcore_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3:0]       arvalid [3];
    logic [3:0]       rready  [3];
    logic [3:0][31:0] araddr  [3];
    logic [3:0][2:0]  arprot  [3];
    logic [3:0]       arready [3];
    logic [3:0]       rvalid  [3];
    logic [31:0]      s_rdata [3];
    logic [1:0]       s_rresp [3];
    logic             m_arvalid [3];
    logic             m_arready [3];
    logic [31:0]      m_araddr  [3];
    logic [2:0]       m_arprot  [3];
    logic             m_rvalid  [3];
    logic             m_rready  [3];
    logic [31:0]      m_rdata   [3];
    logic [1:0]       m_rresp   [3];

    logic [1:0] a0_ardy, a0_rv, a1_ardy, a1_rv;
    logic [3:0] a2_ardy, a2_rv;
    assign arready[0] = {2'b00, a0_ardy};
    assign rvalid[0]  = {2'b00, a0_rv};
    assign arready[1] = {2'b00, a1_ardy};
    assign rvalid[1]  = {2'b00, a1_rv};
    assign arready[2] = a2_ardy;
    assign rvalid[2]  = a2_rv;

    axi_lite_read_arbiter #(.NUM_MASTERS(2), .ARB_MODE(ARB_RR)) u_rr (
        .aclk(clk), .areset(rst_n),
        .s_arvalid(arvalid[0][1:0]), .s_arready(a0_ardy), .s_araddr(araddr[0][1:0]), .s_arprot(arprot[0][1:0]),
        .s_rvalid(a0_rv), .s_rready(rready[0][1:0]), .s_rdata(s_rdata[0]), .s_rresp(s_rresp[0]),
        .m_arvalid(m_arvalid[0]), .m_arready(m_arready[0]), .m_araddr(m_araddr[0]), .m_arprot(m_arprot[0]),
        .m_rvalid(m_rvalid[0]), .m_rready(m_rready[0]), .m_rdata(m_rdata[0]), .m_rresp(m_rresp[0])
    );

    axi_lite_read_arbiter #(.NUM_MASTERS(2), .ARB_MODE(ARB_FIXED)) u_fix (
        .aclk(clk), .areset(rst_n),
        .s_arvalid(arvalid[1][1:0]), .s_arready(a1_ardy), .s_araddr(araddr[1][1:0]), .s_arprot(arprot[1][1:0]),
        .s_rvalid(a1_rv), .s_rready(rready[1][1:0]), .s_rdata(s_rdata[1]), .s_rresp(s_rresp[1]),
        .m_arvalid(m_arvalid[1]), .m_arready(m_arready[1]), .m_araddr(m_araddr[1]), .m_arprot(m_arprot[1]),
        .m_rvalid(m_rvalid[1]), .m_rready(m_rready[1]), .m_rdata(m_rdata[1]), .m_rresp(m_rresp[1])
    );

    axi_lite_read_arbiter #(.NUM_MASTERS(4), .ARB_MODE(ARB_RR)) u_rr4 (
        .aclk(clk), .areset(rst_n),
        .s_arvalid(arvalid[2]), .s_arready(a2_ardy), .s_araddr(araddr[2]), .s_arprot(arprot[2]),
        .s_rvalid(a2_rv), .s_rready(rready[2]), .s_rdata(s_rdata[2]), .s_rresp(s_rresp[2]),
        .m_arvalid(m_arvalid[2]), .m_arready(m_arready[2]), .m_araddr(m_araddr[2]), .m_arprot(m_arprot[2]),
        .m_rvalid(m_rvalid[2]), .m_rready(m_rready[2]), .m_rdata(m_rdata[2]), .m_rresp(m_rresp[2])
    );

    typedef struct {
        int          k;
        int          m;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [1:0]  resp;
    } txn_t;

    txn_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   served[3][4];

    function automatic logic [3:0] mask(input int k);
        return (k == 2) ? 4'hF : 4'h3;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            arvalid[k] = '0;  rready[k] = '1;  araddr[k] = '0;  arprot[k] = '0;
            m_arready[k] = 1'b0;  m_rvalid[k] = 1'b0;  m_rdata[k] = '0;  m_rresp[k] = '0;
            for (int m = 0; m < 4; m++) served[k][m] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic req(input int k, input int m, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] resp);
        txn_t e;
        arvalid[k][m] = 1'b1;
        araddr[k][m]  = addr;
        arprot[k][m]  = 3'(m + 1);
        e.k = k;  e.m = m;  e.addr = addr;  e.prot = 3'(m + 1);  e.data = data;  e.resp = resp;
        sb.push_back(e);
    endtask

    // Acts as the memory for the next expected transaction and checks the master side.
    task automatic serve(input int ar_wait, input int r_wait);
        txn_t e;
        int   n;
        int   k;
        e = sb.pop_front();
        k = e.k;
        n = 0;
        while (m_arvalid[k] !== 1'b1 && n < 30) begin
            @(negedge clk); #1; n++;
        end
        total_cnt++;
        if (m_arvalid[k] !== 1'b1) $display("FAIL ar_timeout: inst %0d m_arvalid=%b required 1", k, m_arvalid[k]);
        else pass_cnt++;
        total_cnt++;
        if ({m_araddr[k], m_arprot[k]} !== {e.addr, e.prot})
            $display("FAIL ar_addr: inst %0d addr=%h prot=%h required addr=%h prot=%h", k, m_araddr[k], m_arprot[k], e.addr, e.prot);
        else pass_cnt++;
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk); #1;
            total_cnt++;
            if (m_arvalid[k] !== 1'b1 || {m_araddr[k], m_arprot[k]} !== {e.addr, e.prot})
                $display("FAIL ar_stable: inst %0d arvalid=%b addr=%h prot=%h required 1 %h %h", k, m_arvalid[k], m_araddr[k], m_arprot[k], e.addr, e.prot);
            else pass_cnt++;
        end
        m_arready[k] = 1'b1;
        @(negedge clk);
        m_arready[k] = 1'b0;
        m_rvalid[k]  = 1'b1;
        m_rdata[k]   = e.data;
        m_rresp[k]   = e.resp;
        if (r_wait > 0) rready[k][e.m] = 1'b0;
        #1;
        total_cnt++;
        if ((rvalid[k] & mask(k)) !== 4'(1 << e.m))
            $display("FAIL r_select: inst %0d s_rvalid=%b required %b", k, rvalid[k] & mask(k), 4'(1 << e.m));
        else pass_cnt++;
        total_cnt++;
        if ({s_rdata[k], s_rresp[k]} !== {e.data, e.resp})
            $display("FAIL r_data: inst %0d data=%h resp=%b required data=%h resp=%b", k, s_rdata[k], s_rresp[k], e.data, e.resp);
        else pass_cnt++;
        for (int i = 0; i < r_wait; i++) begin
            @(negedge clk); #1;
            total_cnt++;
            if (m_rready[k] !== 1'b0 || (rvalid[k] & mask(k)) !== 4'(1 << e.m))
                $display("FAIL r_hold: inst %0d m_rready=%b s_rvalid=%b required 0 %b", k, m_rready[k], rvalid[k] & mask(k), 4'(1 << e.m));
            else pass_cnt++;
        end
        rready[k][e.m] = 1'b1;
        #1;
        total_cnt++;
        if (m_rready[k] !== 1'b1) $display("FAIL m_rready: inst %0d m_rready=%b required 1", k, m_rready[k]);
        else pass_cnt++;
        @(negedge clk);
        #1;
        // m_rvalid still high: a second beat would show up here if the FSM lingered in DATA.
        total_cnt++;
        if ((rvalid[k] & mask(k)) !== 4'b0000 || m_rready[k] !== 1'b0)
            $display("FAIL r_dup: inst %0d s_rvalid=%b m_rready=%b required 0 0", k, rvalid[k] & mask(k), m_rready[k]);
        else pass_cnt++;
        m_rvalid[k] = 1'b0;
        served[k][e.m]++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            arvalid[k] = mask(k);  rready[k] = '1;  araddr[k] = '1;  arprot[k] = '1;
            m_arready[k] = 1'b1;  m_rvalid[k] = 1'b1;  m_rdata[k] = '1;  m_rresp[k] = '1;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ((arready[k] & mask(k)) !== 0 || (rvalid[k] & mask(k)) !== 0 || m_arvalid[k] !== 0 || m_rready[k] !== 0 ||
                m_araddr[k] !== 0 || m_arprot[k] !== 0 || s_rdata[k] !== 0 || s_rresp[k] !== 0)
                $display("FAIL reset_outputs: inst %0d arready=%b rvalid=%b arvalid=%b rready=%b addr=%h prot=%h rdata=%h rresp=%b required all 0",
                         k, arready[k], rvalid[k], m_arvalid[k], m_rready[k], m_araddr[k], m_arprot[k], s_rdata[k], s_rresp[k]);
            else pass_cnt++;
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        arvalid[0][0] = 1'b1;  araddr[0][0] = 32'h0000_0100;  arprot[0][0] = 3'b010;
        #1;
        total_cnt++;
        if ((arready[0] & 4'h3) !== 4'b0001) $display("FAIL single_accept: s_arready=%b required 0001", arready[0] & 4'h3);
        else pass_cnt++;
        @(negedge clk);
        arvalid[0][0] = 1'b0;
        #1;
        total_cnt++;
        if (m_arvalid[0] !== 1'b1 || m_araddr[0] !== 32'h0000_0100 || m_arprot[0] !== 3'b010)
            $display("FAIL single_ar: arvalid=%b addr=%h prot=%b required 1 00000100 010", m_arvalid[0], m_araddr[0], m_arprot[0]);
        else pass_cnt++;
        m_arready[0] = 1'b1;  m_rvalid[0] = 1'b1;  m_rdata[0] = 32'hDEAD_BEEF;  m_rresp[0] = OKAY;
        @(negedge clk);
        m_arready[0] = 1'b0;
        #1;
        total_cnt++;
        if ((rvalid[0] & 4'h3) !== 4'b0001 || s_rdata[0] !== 32'hDEAD_BEEF || s_rresp[0] !== 2'b00)
            $display("FAIL single_r: s_rvalid=%b data=%h resp=%b required 0001 deadbeef 00", rvalid[0] & 4'h3, s_rdata[0], s_rresp[0]);
        else pass_cnt++;
        @(negedge clk);
        m_rvalid[0] = 1'b0;
        #1;
        total_cnt++;
        if ((rvalid[0] & 4'h3) !== 4'b0000) $display("FAIL single_done: s_rvalid=%b required 00", rvalid[0] & 4'h3);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        do_reset();
        req(0, 0, 32'h10, 32'hA000_0001, OKAY);
        req(0, 1, 32'h20, 32'hA000_0002, OKAY);
        req(0, 0, 32'h10, 32'hA000_0003, OKAY);
        req(0, 1, 32'h20, 32'hA000_0004, OKAY);
        repeat (4) serve(0, 0);
        arvalid[0] = '0;
        total_cnt++;
        if (served[0][0] !== 2 || served[0][1] !== 2)
            $display("FAIL rr_fair: served m0=%0d m1=%0d required 2 2", served[0][0], served[0][1]);
        else pass_cnt++;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        repeat (3) req(1, 0, 32'h10, 32'hB000_0000, OKAY);
        arvalid[1][1] = 1'b1;  araddr[1][1] = 32'h20;  arprot[1][1] = 3'd2;
        repeat (3) serve(0, 0);
        arvalid[1][0] = 1'b0;
        req(1, 1, 32'h20, 32'hB000_0011, EXOKAY);
        serve(0, 0);
        arvalid[1] = '0;
        total_cnt++;
        if (served[1][0] !== 3 || served[1][1] !== 1)
            $display("FAIL fixed_count: served m0=%0d m1=%0d required 3 1", served[1][0], served[1][1]);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        req(0, 1, 32'h0000_0044, 32'hC0DE_0044, EXOKAY);
        serve(5, 3);
        arvalid[0] = '0;
        total_cnt++;
        if (served[0][1] !== 1) $display("FAIL bp_single_beat: served=%0d required 1", served[0][1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        arvalid[0][0] = 1'b1;  araddr[0][0] = 32'h40;  arprot[0][0] = 3'd1;
        @(negedge clk);
        arvalid[0][0] = 1'b0;
        m_arready[0]  = 1'b1;
        @(negedge clk);
        m_arready[0]  = 1'b0;
        m_rvalid[0]   = 1'b1;  m_rdata[0] = 32'h5555_AAAA;  m_rresp[0] = DECERR;
        rready[0][0]  = 1'b0;
        arvalid[0][1] = 1'b1;  araddr[0][1] = 32'h80;  arprot[0][1] = 3'd2;
        #1;
        total_cnt++;
        if ((rvalid[0] & 4'h3) !== 4'b0001) $display("FAIL mid_in_data: s_rvalid=%b required 01", rvalid[0] & 4'h3);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ((arready[0] & 4'h3) !== 0 || (rvalid[0] & 4'h3) !== 0 || m_arvalid[0] !== 0 || m_rready[0] !== 0 ||
            m_araddr[0] !== 0 || m_arprot[0] !== 0 || s_rdata[0] !== 0 || s_rresp[0] !== 0)
            $display("FAIL async_reset: arready=%b rvalid=%b arvalid=%b rready=%b addr=%h prot=%h rdata=%h rresp=%b required all 0",
                     arready[0], rvalid[0], m_arvalid[0], m_rready[0], m_araddr[0], m_arprot[0], s_rdata[0], s_rresp[0]);
        else pass_cnt++;
        @(negedge clk);
        m_rvalid[0] = 1'b0;
        rready[0]   = '1;
        rst_n       = 1'b1;
        req(0, 1, 32'h80, 32'h0000_0080, OKAY);
        #1;
        total_cnt++;
        if ((arready[0] & 4'h3) !== 4'b0010) $display("FAIL post_reset_grant: s_arready=%b required 10", arready[0] & 4'h3);
        else pass_cnt++;
        serve(0, 0);
        req(0, 0, 32'h90, 32'h0000_0090, OKAY);
        serve(0, 0);
        arvalid[0] = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        req(2, 2, 32'h200, 32'hD000_0002, OKAY);
        serve(0, 0);
        arvalid[2] = '0;
        req(2, 3, 32'h300, 32'hD000_0003, SLVERR);
        req(2, 0, 32'h000, 32'hD000_0000, DECERR);
        #1;
        total_cnt++;
        if ((arready[2] & 4'hF) !== 4'b1000) $display("FAIL wrap_grant: s_arready=%b required 1000", arready[2]);
        else pass_cnt++;
        serve(0, 0);
        serve(0, 0);
        arvalid[2] = '0;
        total_cnt++;
        if (served[2][3] !== 1 || served[2][0] !== 1)
            $display("FAIL wrap_count: served m3=%0d m0=%0d required 1 1", served[2][3], served[2][0]);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_back_pressure();
        test_reset_mid();
        test_wrap();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_leftover: entries=%0d required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_lite_read_arbiter.md
# axi_lite_read_arbiter

Parametrised N-to-1 AXI4-Lite read-channel arbiter that merges several read masters (i_cache, d_cache, and later a debug or DMA port) onto one read port of `axi_memory`. It replaces the current dedicated dual read-port wiring at the top level, so the memory needs only a single read port regardless of master count. Arbitration is round-robin or fixed-priority, selected by parameter. One transaction is in flight at a time, and the request address is registered.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of upstream read masters, 2..8
- `ADDR_WIDTH`, 32: araddr width
- `DATA_WIDTH`, 32: rdata width
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- `aclk` in 1: single clock, rising edge
- `areset` in 1: reset, asynchronous, active-low
- `s_arvalid` in [NUM_MASTERS]: per-master read request
- `s_arready` out [NUM_MASTERS]: per-master address accept
- `s_araddr` in [NUM_MASTERS][ADDR_WIDTH]: per-master address
- `s_arprot` in [NUM_MASTERS][3]: per-master protection bits
- `s_rvalid` out [NUM_MASTERS]: per-master read data valid
- `s_rready` in [NUM_MASTERS]: per-master read data accept
- `s_rdata` out DATA_WIDTH: read data, broadcast to all masters
- `s_rresp` out 2: read response, broadcast to all masters
- `m_arvalid` out 1, `m_arready` in 1, `m_araddr` out ADDR_WIDTH, `m_arprot` out 3: downstream address channel
- `m_rvalid` in 1, `m_rready` out 1, `m_rdata` in DATA_WIDTH, `m_rresp` in 2: downstream data channel

## Operation
- FSM states are IDLE, ADDR and DATA.
- **IDLE**
  - If any `s_arvalid` is high, compute the grant index `g` and drive `s_arready[g]=1` combinationally.
  - Latch `s_araddr[g]`, `s_arprot[g]` and `g` on the clock edge, then go to ADDR.
  - All other `s_arready` are 0.
- **ADDR**
  - `m_arvalid=1` and `m_araddr`/`m_arprot` come from the registers.
  - On `m_arready`, go to DATA.
  - Address and prot registers stay stable while `m_arready` is low.
- **DATA**
  - `s_rvalid[g]=m_rvalid`, `m_rready=s_rready[g]`, and every other `s_rvalid` is 0.
  - On `m_rvalid & s_rready[g]`, go to IDLE and update the round-robin pointer to `g+1` (mod NUM_MASTERS).
- **Round-robin:** search starts at the pointer and wraps, so the pointer position is the highest priority.
- **Fixed priority:** the lowest asserted index wins, and the pointer is ignored.
- Requests are sampled only in IDLE. A master that holds `s_arvalid` while another is served simply waits; requests are never lost or reordered per master.
- `m_rresp` is passed through unchanged, including SLVERR and DECERR.
- `NUM_MASTERS=1` degenerates to a registered pass-through with the same latency.

## Timing
- **Reset values:** state is IDLE, the pointer is 0, and `g` is 0.
  - `s_arready`, `s_rvalid`, `m_arvalid` and `m_rready` are all 0.
  - `m_araddr`, `m_arprot`, `s_rdata` and `s_rresp` are 0.
- **Asynchronous reset mid-transaction:** abort to IDLE immediately. Any outstanding downstream beat is the memory's responsibility, because both ends share the same reset.
- **Minimum latency:**
  - cycle 0: request accepted
  - cycle 1: `m_arvalid` high; with memory `arready` this cycle, go to DATA
  - cycle 2 at the earliest: `s_rvalid`
- **Throughput:** at most one transaction per 3 cycles. The new grant is computed in the IDLE cycle directly after the data handshake.
- **Simultaneous events:** all masters requesting in the same IDLE cycle produces exactly one grant, chosen by mode.
- **Pointer wrap:** `NUM_MASTERS-1` wraps to 0.
- **Combinational paths:**
  - `s_arready` depends combinationally on `s_arvalid`.
  - `m_rready` depends combinationally on `s_rready`.
  - `m_arvalid` comes from the state register.

## Structure
- Shared package `rvcore_axi_pkg` holds:
  - the `axi_resp_t` enum (OKAY/EXOKAY/SLVERR/DECERR)
  - the `arb_state_t` enum (IDLE/ADDR/DATA)
  - the constants `ARB_RR=0` and `ARB_FIXED=1`
- Sub-module `rr_arbiter` (parameter `N`) contains the grant logic:
  - inputs: request vector, pointer, mode
  - output: one-hot grant plus encoded index
  - purely combinational, reusable later for a write arbiter

## Test plan
1. Single master 0 reads 0x0000_0100 while memory returns 0xDEAD_BEEF with OKAY -> `s_rvalid[0]` asserts 2 cycles after accept, data 0xDEAD_BEEF, `s_rvalid[1]` stays 0.
2. RR mode, masters 0 and 1 request together continuously at addresses 0x10 and 0x20 -> `m_araddr` sequence is 0x10, 0x20, 0x10, 0x20 and each master is served exactly twice in 4 transactions.
3. Fixed mode, masters 0 and 1 requesting continuously -> master 0 is always granted and master 1 is starved. Master 0 then drops its request -> master 1 is served next.
4. `m_arready` held low 5 cycles and `s_rready[g]` held low 3 cycles after `m_rvalid` -> `m_araddr` and `m_arprot` are stable throughout, and exactly one beat is delivered with no duplicate.
5. `areset` asserted low while in DATA -> all outputs are 0 asynchronously. After release, a new request from master 1 is granted with the pointer at 0.
6. `NUM_MASTERS=4` in RR mode, requests on masters 3 and 0 with the pointer at 3 -> master 3 is granted, the pointer wraps to 0, and master 0 is granted next. An SLVERR response is forwarded unchanged.
